// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings and widths for the ground scroller
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam int PATTERN_LEN = 40;
    localparam int SPEED_W     = 4;
    localparam int POS_W       = 6;
    localparam int SCORE_W     = 16;

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - registered single-cycle edge detector, rising or falling
module edge_pulse #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev;

    // pulse is registered, so it appears the cycle after the new level is sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= d;
            pulse <= FALLING ? (prev & ~d) : (~prev & d);
        end
    end

endmodule

// File: rtl/ground_scroll_scheduler.sv
// rtl/ground_scroll_scheduler.sv - run/over sequencer, speed ramp and ground scroll offset
module ground_scroll_scheduler
    import game_pkg::*;
#(
    parameter int PATTERN_LEN_P = PATTERN_LEN,
    parameter int SPEED_INIT    = 1,
    parameter int SPEED_MAX     = 7,
    parameter int RAMP_FRAMES   = 600,
    parameter int OVER_FRAMES   = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fresh,
    input  logic               start,
    input  logic               collision,
    output logic               game_status,
    output logic [SPEED_W-1:0] speed,
    output logic [POS_W-1:0]   ground_position,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state_o
);

    localparam int RW = $clog2(RAMP_FRAMES + 1);
    localparam int OW = $clog2(OVER_FRAMES + 1);
    localparam logic [RW-1:0]      RAMP_LAST  = RW'(RAMP_FRAMES - 1);
    localparam logic [OW-1:0]      OVER_MAX   = OW'(OVER_FRAMES);
    localparam logic [SPEED_W-1:0] SPD_INIT   = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(SPEED_MAX);
    localparam logic [6:0]         PLEN7      = 7'(PATTERN_LEN_P);

    logic frame_tick;
    logic start_rise;

    edge_pulse #(.FALLING(1'b1)) u_fresh_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (fresh),
        .pulse (frame_tick)
    );

    edge_pulse #(.FALLING(1'b0)) u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (start),
        .pulse (start_rise)
    );

    game_state_t        state, state_n;
    logic [RW-1:0]      ramp_cnt, ramp_n;
    logic [OW-1:0]      over_cnt, over_n;
    logic [SPEED_W-1:0] speed_n, speed_inc;
    logic [POS_W-1:0]   pos_n, pos_wrap;
    logic [SCORE_W-1:0] score_n, score_inc;
    logic [6:0]         sum7;

    // single conditional subtract suffices since position < PATTERN_LEN and speed <= 15
    assign sum7      = {1'b0, ground_position} + 7'(speed);
    assign pos_wrap  = (sum7 >= PLEN7) ? POS_W'(sum7 - PLEN7) : POS_W'(sum7);
    assign speed_inc = (speed < SPD_MAX) ? speed + 1'b1 : speed;
    assign score_inc = (score != {SCORE_W{1'b1}}) ? score + 1'b1 : score;

    always_comb begin
        state_n = state;
        speed_n = speed;
        pos_n   = ground_position;
        score_n = score;
        ramp_n  = ramp_cnt;
        over_n  = over_cnt;
        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_n = ST_RUN;
                    speed_n = SPD_INIT;
                    pos_n   = '0;
                    score_n = '0;
                    ramp_n  = '0;
                end
            end
            ST_RUN: begin
                // a hit wins over a coincident frame tick: the last frame is not applied
                if (collision) begin
                    state_n = ST_OVER;
                    over_n  = '0;
                end else if (frame_tick) begin
                    pos_n   = pos_wrap;
                    score_n = score_inc;
                    if (ramp_cnt == RAMP_LAST) begin
                        ramp_n  = '0;
                        speed_n = speed_inc;
                    end else begin
                        ramp_n = ramp_cnt + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise && over_cnt == OVER_MAX) begin
                    state_n = ST_IDLE;
                    speed_n = SPD_INIT;
                    pos_n   = '0;
                    score_n = '0;
                    ramp_n  = '0;
                    over_n  = '0;
                end else if (frame_tick && over_cnt != OVER_MAX) begin
                    over_n = over_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                speed_n = SPD_INIT;
                pos_n   = '0;
                score_n = '0;
                ramp_n  = '0;
                over_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            game_status     <= 1'b0;
            speed           <= SPD_INIT;
            ground_position <= '0;
            score           <= '0;
            ramp_cnt        <= '0;
            over_cnt        <= '0;
        end else begin
            state           <= state_n;
            game_status     <= (state_n == ST_RUN);
            speed           <= speed_n;
            ground_position <= pos_n;
            score           <= score_n;
            ramp_cnt        <= ramp_n;
            over_cnt        <= over_n;
        end
    end

    assign state_o = state;

endmodule
